pair_triple_arbiter: RTL

Round-robin arbiter and sequencer that shares one pair/triple (2-of-3 majority) detector datapath among four requesters. Each requester presents a 3-bit vote under a val/rdy handshake. The arbiter grants one requester per cycle, registers the detector result with the winner's ID, and returns it on a single val/rdy response port. It also keeps a saturating count of positive detections, which the system uses as a vote-stream health monitor.

---
 rtl/pair_triple_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/pair_triple_arbiter.sv
// Round-robin arbiter sharing one 2-of-3 majority / triple detector among four
// requesters, with a one-entry response register and a saturating hit counter.
module pair_triple_arbiter #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_val,
  input  logic [11:0]        req_bits,
  output logic [3:0]         req_rdy,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [1:0]         resp_id,
  output logic               resp_out,
  output logic               resp_triple,
  output logic [COUNT_W-1:0] count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         ptr_reg;
  logic [1:0]         resp_id_reg;
  logic               resp_out_reg, resp_triple_reg;
  logic [COUNT_W-1:0] count_reg;

  logic [2:0] vote [4];
  logic [3:0] rot;
  logic [1:0] offset;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       can_accept, transfer, drain;
  logic [2:0] sel_vote;
  logic       det_out, det_triple;

  // rot[k] is the request k places after the current priority pointer
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_req
      assign vote[gi]    = req_bits[3*gi +: 3];
      assign rot[gi]     = req_val[ptr_reg + 2'(gi)];
      assign req_rdy[gi] = transfer && (grant_idx == 2'(gi));
    end
  endgenerate

  always_comb begin
    grant_valid = 1'b0;
    offset      = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) begin
        grant_valid = 1'b1;
        offset      = 2'(k);
      end
    end
  end

  assign grant_idx  = ptr_reg + offset;
  assign can_accept = (state_reg == EMPTY) || resp_rdy;
  // Gating with rst keeps the grant low for the whole reset pulse
  assign transfer   = grant_valid && can_accept && !rst;
  assign drain      = (state_reg == FULL) && resp_rdy;

  assign sel_vote   = vote[grant_idx];
  assign det_out    = (sel_vote[0] & sel_vote[1]) | ((sel_vote[0] | sel_vote[1]) & sel_vote[2]);
  assign det_triple = &sel_vote;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (transfer)   state_next = FULL;
    else if (drain) state_next = EMPTY;
  end

  always_comb begin
    resp_val = (state_reg == FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg         <= 2'd0;
      resp_id_reg     <= 2'd0;
      resp_out_reg    <= 1'b0;
      resp_triple_reg <= 1'b0;
    end else if (transfer) begin
      ptr_reg         <= grant_idx + 2'd1;
      resp_id_reg     <= grant_idx;
      resp_out_reg    <= det_out;
      resp_triple_reg <= det_triple;
    end
  end

  // Counts the outgoing response, so a same-edge reload does not affect it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_reg <= '0;
    else if (drain && resp_out_reg && (count_reg != {COUNT_W{1'b1}}))
      count_reg <= count_reg + 1'b1;
  end

  assign resp_id     = resp_id_reg;
  assign resp_out    = resp_out_reg;
  assign resp_triple = resp_triple_reg;
  assign count       = count_reg;

endmodule
